// File: rtl/mtimer_mmap_if.sv
// Word device port between the mmu (master) and a memory-mapped slave.
// Read data is combinational; writes are whole 32-bit words.
interface mtimer_mmap_if;
  logic        re;
  logic [31:0] rd;
  logic        we;
  logic [31:0] wd;
  logic [29:0] addr;

  modport master (output re, output we, output wd, output addr, input rd);
  modport slave  (input re, input we, input wd, input addr, output rd);
endinterface

// File: rtl/mtimer_mmap.sv
// Machine timer: prescaled free-running 64-bit mtime plus CHANNELS compare
// channels with optional periodic auto-reload, sticky pending bits and maskable irqs.
module mtimer_mmap #(
  parameter int CHANNELS       = 1,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  mtimer_mmap_if.slave        bus,
  output logic [63:0]         mtime,
  output logic [CHANNELS-1:0] irq
);
  localparam int PW = PRESCALE_WIDTH;

  localparam logic [5:0] W_MTIME_LO = 6'h00;
  localparam logic [5:0] W_MTIME_HI = 6'h01;
  localparam logic [5:0] W_CTRL     = 6'h02;
  localparam logic [5:0] W_IRQ_EN   = 6'h03;
  localparam logic [5:0] W_PENDING  = 6'h04;

  // Address decode: word index within the 256-byte window
  logic [5:0] word;
  logic       ch_space;
  logic [3:0] ch_sel;
  logic [1:0] ch_reg;
  logic       unused_addr;

  assign word        = bus.addr[5:0];
  assign ch_space    = (word[5:3] != 3'd0);
  assign ch_sel      = word[5:2] - 4'd2;
  assign ch_reg      = word[1:0];
  assign unused_addr = ^bus.addr[29:6];

  logic wr_mtime_lo;
  logic wr_mtime_hi;
  logic wr_ctrl;
  logic wr_irq_en;
  logic wr_pending;

  assign wr_mtime_lo = bus.we && (word == W_MTIME_LO);
  assign wr_mtime_hi = bus.we && (word == W_MTIME_HI);
  assign wr_ctrl     = bus.we && (word == W_CTRL);
  assign wr_irq_en   = bus.we && (word == W_IRQ_EN);
  assign wr_pending  = bus.we && (word == W_PENDING);

  logic [63:0]         mtime_reg;
  logic [63:0]         mtime_next;
  logic [PW-1:0]       pc_reg;
  logic [PW-1:0]       pc_next;
  logic [PW-1:0]       prescale_reg;
  logic                en_reg;
  logic                tick;
  logic [CHANNELS-1:0] irq_en_reg;
  logic [CHANNELS-1:0] pending_reg;
  logic [CHANNELS-1:0] pending_next;
  logic [CHANNELS-1:0] irq_reg;
  logic [CHANNELS-1:0] match;

  logic [CHANNELS-1:0][63:0] cmp_all;
  logic [CHANNELS-1:0][31:0] period_all;

  assign tick = en_reg && (pc_reg == prescale_reg);

  always_comb begin
    pc_next = pc_reg;
    if (wr_ctrl) begin
      pc_next = '0;
    end else if (tick) begin
      pc_next = '0;
    end else if (en_reg) begin
      pc_next = pc_reg + PW'(1);
    end
  end

  // A half-word load replaces the tick for that cycle; the other half holds.
  always_comb begin
    mtime_next = mtime_reg;
    if (wr_mtime_lo) begin
      mtime_next[31:0] = bus.wd;
    end else if (wr_mtime_hi) begin
      mtime_next[63:32] = bus.wd;
    end else if (tick) begin
      mtime_next = mtime_reg + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mtime_reg    <= '0;
      pc_reg       <= '0;
      en_reg       <= 1'b1;
      prescale_reg <= '0;
      irq_en_reg   <= '0;
      pending_reg  <= '0;
      irq_reg      <= '0;
    end else begin
      mtime_reg   <= mtime_next;
      pc_reg      <= pc_next;
      pending_reg <= pending_next;
      irq_reg     <= pending_next & irq_en_reg;
      if (wr_ctrl) begin
        en_reg       <= bus.wd[0];
        prescale_reg <= bus.wd[PW+15:16];
      end
      if (wr_irq_en) begin
        irq_en_reg <= bus.wd[CHANNELS-1:0];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic        sel;
      logic        wr_cmp_lo;
      logic        wr_cmp_hi;
      logic        wr_period;
      logic        cmp_write;
      logic        w1c;
      logic [63:0] cmp_reg;
      logic [31:0] period_reg;

      assign sel       = bus.we && ch_space && (ch_sel == 4'(gi));
      assign wr_cmp_lo = sel && (ch_reg == 2'd0);
      assign wr_cmp_hi = sel && (ch_reg == 2'd1);
      assign wr_period = sel && (ch_reg == 2'd2);
      assign cmp_write = wr_cmp_lo || wr_cmp_hi;
      assign w1c       = wr_pending && bus.wd[gi];

      assign match[gi] = (mtime_reg >= cmp_reg);

      // Match sets over a W1C, but a compare rewrite re-arms the channel:
      // the match against the compare value being replaced is discarded.
      assign pending_next[gi] = (match[gi] && !cmp_write) ||
                                (pending_reg[gi] && !(cmp_write || w1c));

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cmp_reg    <= '1;
          period_reg <= '0;
        end else begin
          if (wr_cmp_lo) begin
            cmp_reg[31:0] <= bus.wd;
          end else if (wr_cmp_hi) begin
            cmp_reg[63:32] <= bus.wd;
          end else if (match[gi] && (period_reg != 32'd0)) begin
            cmp_reg <= cmp_reg + {32'd0, period_reg};
          end
          if (wr_period) begin
            period_reg <= bus.wd;
          end
        end
      end

      assign cmp_all[gi]    = cmp_reg;
      assign period_all[gi] = period_reg;
    end
  endgenerate

  logic [31:0] ctrl_word;
  logic [31:0] rd_word;

  always_comb begin
    ctrl_word              = 32'd0;
    ctrl_word[0]           = en_reg;
    ctrl_word[PW+15:16]    = prescale_reg;
  end

  always_comb begin
    rd_word = 32'd0;
    if (ch_space) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (ch_sel == 4'(i)) begin
          case (ch_reg)
            2'd0:    rd_word = cmp_all[i][31:0];
            2'd1:    rd_word = cmp_all[i][63:32];
            2'd2:    rd_word = period_all[i];
            default: rd_word = 32'd0;
          endcase
        end
      end
    end else begin
      case (word[2:0])
        3'd0:    rd_word = mtime_reg[31:0];
        3'd1:    rd_word = mtime_reg[63:32];
        3'd2:    rd_word = ctrl_word;
        3'd3:    rd_word = 32'(irq_en_reg);
        3'd4:    rd_word = 32'(pending_reg);
        default: rd_word = 32'd0;
      endcase
    end
  end

  assign bus.rd = bus.re ? rd_word : 32'd0;
  assign mtime  = mtime_reg;
  assign irq    = irq_reg;
endmodule

// File: tb/tb_mtimer_mmap.sv
// Randomized scoreboard bench for mtimer_mmap: a per-edge timer model predicts
// read data, mtime and irq; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_mtimer_mmap;
  localparam int CH = 2;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [63:0]   mtime;
  logic [CH-1:0] irq;

  mtimer_mmap_if bus ();

  mtimer_mmap #(.CHANNELS(CH), .PRESCALE_WIDTH(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .mtime (mtime),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            re;
    bit            we;
    logic [7:0]    off;
    logic [31:0]   wd;
    logic [31:0]   rd;
    logic [63:0]   mtime;
    logic [CH-1:0] irq;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state
  bit [63:0]       m_mtime;
  bit              m_en;
  int unsigned     m_ps;
  longint unsigned m_phase;
  bit [CH-1:0]     m_irqen;
  bit [CH-1:0]     m_pend;
  bit [CH-1:0]     m_irq;
  bit [63:0]       m_cmp [CH];
  bit [31:0]       m_per [CH];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_mtime = 64'd0;
    m_en    = 1'b1;
    m_ps    = 0;
    m_phase = 0;
    m_irqen = '0;
    m_pend  = '0;
    m_irq   = '0;
    for (int i = 0; i < CH; i++) begin
      m_cmp[i] = '1;
      m_per[i] = '0;
    end
  endfunction

  function automatic logic [31:0] model_read(logic [5:0] w);
    int unsigned b;
    int unsigned c;
    int unsigned s;
    logic [31:0] r;
    b = int'(w) * 4;
    r = 32'd0;
    case (b)
      0:  r = m_mtime[31:0];
      4:  r = m_mtime[63:32];
      8:  r = (m_ps << 16) | 32'(m_en);
      12: r = 32'(m_irqen);
      16: r = 32'(m_pend);
      default: begin
        if (b >= 32) begin
          c = (b - 32) / 16;
          s = b % 16;
          if (c < CH) begin
            if (s == 0)      r = m_cmp[c][31:0];
            else if (s == 4) r = m_cmp[c][63:32];
            else if (s == 8) r = m_per[c];
          end
        end
      end
    endcase
    return r;
  endfunction

  // Advance the model across one rising edge given that cycle's bus inputs.
  function automatic void model_step(bit we, logic [5:0] w, logic [31:0] wd);
    int unsigned b;
    int unsigned c;
    int unsigned s;
    bit          tick;
    bit [CH-1:0] hit;
    bit [CH-1:0] newp;
    b = int'(w) * 4;
    c = (b >= 32) ? (b - 32) / 16 : 99;
    s = b % 16;
    tick = m_en && ((m_phase % (longint'(m_ps) + 1)) == longint'(m_ps));
    for (int i = 0; i < CH; i++) begin
      hit[i]  = (m_mtime >= m_cmp[i]);
      newp[i] = hit[i] || (m_pend[i] && !(we && b == 16 && wd[i]));
    end
    if (m_en) m_phase++;
    if (we && b == 0)      m_mtime[31:0]  = wd;
    else if (we && b == 4) m_mtime[63:32] = wd;
    else if (tick)         m_mtime        = m_mtime + 64'd1;
    for (int i = 0; i < CH; i++) begin
      if (we && c == i && (s == 0 || s == 4)) begin
        if (s == 0) m_cmp[i][31:0] = wd;
        else        m_cmp[i][63:32] = wd;
        newp[i] = 1'b0;
      end else if (hit[i] && m_per[i] != 0) begin
        m_cmp[i] = m_cmp[i] + {32'd0, m_per[i]};
      end
      if (we && c == i && s == 8) m_per[i] = wd;
    end
    m_irq  = newp & m_irqen;
    m_pend = newp;
    if (we && b == 12) m_irqen = wd[CH-1:0];
    if (we && b == 8) begin
      m_en    = wd[0];
      m_ps    = int'(wd[31:16]);
      m_phase = 0;
    end
  endfunction

  task automatic cyc(bit re, bit we, logic [7:0] off, logic [31:0] wd);
    exp_t       e;
    logic [5:0] w;
    w        = off[7:2];
    bus.re   = re;
    bus.we   = we;
    bus.wd   = wd;
    bus.addr = {24'($urandom), w};
    e.re     = re;
    e.we     = we;
    e.off    = off;
    e.wd     = wd;
    e.rd     = re ? model_read(w) : 32'd0;
    e.mtime  = m_mtime;
    e.irq    = m_irq;
    exp_q.push_back(e);
    @(posedge clk);
    model_step(we, w, wd);
    #1;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 8'h00, 32'd0);
  endtask

  task automatic wr(logic [7:0] off, logic [31:0] d);
    cyc(1'b0, 1'b1, off, d);
  endtask

  task automatic rdreg(logic [7:0] off);
    cyc(1'b1, 1'b0, off, 32'd0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("mtime", mtime, mon_e.mtime);
      check("irq", 64'(irq), 64'(mon_e.irq));
      if (mon_e.re) check("rd", 64'(bus.rd), 64'(mon_e.rd));
      else          check("rd_idle", 64'(bus.rd), 64'd0);
      if (mon_e.re || mon_e.we)
        $display("txn t=%0t re=%0d we=%0d off=%h wd=%h rd=%h", $time,
                 mon_e.re, mon_e.we, mon_e.off, mon_e.wd, bus.rd);
    end
  end

  bit [63:0]   t0;
  int unsigned kind;
  int unsigned ch;
  bit          rnd_re;
  bit [63:0]   tgt;
  logic [31:0] d;

  initial begin
    bus.re = 1'b0;
    bus.we = 1'b0;
    bus.wd = 32'd0;
    bus.addr = 30'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Idle from reset with a tick every cycle
    idle(10);
    check("reset_idle_mtime", mtime, 64'd10);
    check("reset_idle_irq", 64'(irq), 64'd0);
    rdreg(8'h10);
    rdreg(8'h08);

    // Prescale by 4, then freeze
    wr(8'h08, 32'h0003_0001);
    t0 = m_mtime;
    idle(40);
    check("prescale_advance", mtime, t0 + 64'd10);
    wr(8'h08, 32'h0000_0000);
    idle(5);
    check("frozen", mtime, t0 + 64'd10);
    rdreg(8'h08);
    wr(8'h08, 32'h0000_0001);

    // Carry from LO into HI
    wr(8'h04, 32'h0);
    wr(8'h00, 32'hFFFF_FFFE);
    idle(3);
    check("carry", mtime, 64'h1_0000_0001);

    // One-shot channel 0
    wr(8'h04, 32'h0);
    wr(8'h00, 32'h0);
    wr(8'h24, 32'h0);
    wr(8'h20, 32'd100);
    wr(8'h0C, 32'h1);
    for (int k = 0; k < 300 && m_mtime != 64'd100; k++) idle(1);
    check("oneshot_reach", mtime, 64'd100);
    check("oneshot_pre_irq", 64'(irq), 64'd0);
    idle(1);
    check("oneshot_irq", 64'(irq), 64'd1);
    wr(8'h10, 32'h1);
    check("w1c_while_match", 64'(irq), 64'd1);
    wr(8'h20, 32'd1000);
    check("rearm_drop", 64'(irq), 64'd0);

    // Periodic channel 1
    wr(8'h00, 32'h0);
    wr(8'h38, 32'd20);
    wr(8'h34, 32'h0);
    wr(8'h30, 32'd50);
    wr(8'h0C, 32'h3);
    for (int k = 0; k < 300 && m_mtime != 64'd50; k++) idle(1);
    check("periodic_reach", mtime, 64'd50);
    idle(1);
    check("periodic_irq", 64'(irq), 64'b10);
    bus.re = 1'b1;
    bus.addr = 30'h0C;
    #1 check("reload_70", 64'(bus.rd), 64'd70);
    bus.re = 1'b0;
    for (int k = 0; k < 300 && m_mtime != 64'd111; k++) rdreg(8'h30);
    check("periodic_hold", 64'(irq), 64'b10);
    rdreg(8'h30);
    wr(8'h10, 32'h2);
    check("periodic_w1c", 64'(irq), 64'd0);

    // Asynchronous reset while irq is high
    for (int k = 0; k < 100 && m_irq == '0; k++) idle(1);
    check("irq_before_reset", 64'(irq), 64'b10);
    bus.re = 1'b1;
    bus.addr = 30'h08;
    reset = 1'b0;
    #1;
    check("async_mtime", mtime, 64'd0);
    check("async_irq", 64'(irq), 64'd0);
    check("async_cmp", 64'(bus.rd), 64'hFFFF_FFFF);
    reset = 1'b1;
    bus.re = 1'b0;
    model_reset();
    idle(3);
    check("post_reset_tick", mtime, 64'd3);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      kind   = $urandom_range(0, 9);
      ch     = $urandom_range(0, CH - 1);
      rnd_re = 1'($urandom_range(0, 1));
      case (kind)
        0, 1, 2: cyc(rnd_re, 1'b0, {6'($urandom), 2'b00}, 32'd0);
        3: begin
          tgt = m_mtime + 64'($urandom_range(0, 30));
          cyc(rnd_re, 1'b1, 8'(32 + 16 * ch), tgt[31:0]);
        end
        4: begin
          tgt = m_mtime + 64'($urandom_range(0, 30));
          cyc(rnd_re, 1'b1, 8'(36 + 16 * ch), tgt[63:32]);
        end
        5: begin
          d = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 25));
          cyc(rnd_re, 1'b1, 8'(40 + 16 * ch), d);
        end
        6: begin
          d = (32'($urandom_range(0, 2)) << 16) | ($urandom & 32'h0000_FFFE) |
              32'($urandom_range(0, 5) != 0);
          cyc(rnd_re, 1'b1, 8'h08, d);
        end
        7: cyc(rnd_re, 1'b1, ($urandom_range(0, 1) == 1) ? 8'h0C : 8'h10, $urandom);
        8: begin
          if ($urandom_range(0, 1) == 1) cyc(rnd_re, 1'b1, 8'h00, 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)));
          else                           cyc(rnd_re, 1'b1, 8'h04, 32'($urandom_range(0, 1)));
        end
        default: begin
          d = $urandom;
          if (d[31:16] > 16'h0003 && $urandom_range(0, 1) == 1) d[31:16] = 16'h0001;
          cyc(rnd_re, 1'b1, {6'($urandom), 2'b00}, d);
        end
      endcase
    end
    idle(2);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
